// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles 6-byte command frames (AA 55 ADDR DH DL CSUM)
// from the uart_byte_rx byte stream, validates header and checksum, and emits
// a one-cycle command strobe with address/data. Partial frames that go idle
// for too long are abandoned with a timeout pulse.
module uart_cmd_parser #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned TIMEOUT_BYTES = 4,
  parameter int unsigned TIMEOUT_CLKS  = (CLK_FREQ / BAUD) * 10 * TIMEOUT_BYTES
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        csum_err,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
  // Firing on the edge that would advance the count to TIMEOUT_CLKS-1 puts
  // timeout_err high exactly TIMEOUT_CLKS-1 cycles after the last rx_done.
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CLKS - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] HDR1_BYTE = 8'hAA;
  localparam logic [7:0] HDR2_BYTE = 8'h55;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR2 = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATH = 3'd3;
  localparam logic [2:0] S_DATL = 3'd4;
  localparam logic [2:0] S_CSUM = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       addr_sh, dh_sh, dl_sh;
  logic [7:0]       sum_c;
  logic             valid_nxt, cerr_nxt, tmo_nxt;

  assign sum_c = addr_sh + dh_sh + dl_sh;

  // State and idle-timeout counter registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and pulse decode; a received byte beats the timeout
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = 1'b0;
    cerr_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    if (rx_done) begin
      cnt_nxt = '0;
      case (state)
        S_IDLE: if (rx_data == HDR1_BYTE) state_nxt = S_HDR2;
        S_HDR2: begin
          if (rx_data == HDR2_BYTE)      state_nxt = S_ADDR;
          else if (rx_data != HDR1_BYTE) state_nxt = S_IDLE;
        end
        S_ADDR: state_nxt = S_DATH;
        S_DATH: state_nxt = S_DATL;
        S_DATL: state_nxt = S_CSUM;
        S_CSUM: begin
          state_nxt = S_IDLE;
          if (rx_data == sum_c) valid_nxt = 1'b1;
          else                  cerr_nxt  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state == S_IDLE) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_TC) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      tmo_nxt   = 1'b1;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Shadow registers for the frame payload bytes
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_sh <= '0;
      dh_sh   <= '0;
      dl_sh   <= '0;
    end else if (rx_done) begin
      if (state == S_ADDR) addr_sh <= rx_data;
      if (state == S_DATH) dh_sh   <= rx_data;
      if (state == S_DATL) dl_sh   <= rx_data;
    end
  end

  // Registered strobes and command payload, updated only on a good frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_valid   <= 1'b0;
      csum_err    <= 1'b0;
      timeout_err <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
    end else begin
      cmd_valid   <= valid_nxt;
      csum_err    <= cerr_nxt;
      timeout_err <= tmo_nxt;
      if (valid_nxt) begin
        cmd_addr <= addr_sh;
        cmd_data <= {dh_sh, dl_sh};
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a table of frames with fixed
// expectations, hand sequences for timeout/race/reset/back-to-back, and a
// random byte stream compared cycle by cycle against a frame-level model.
module tb_uart_cmd_parser;

  localparam int unsigned CLK_FREQ = 1_152_000;
  localparam int unsigned BAUD     = 115_200;
  localparam int          T        = (1_152_000 / 115_200) * 10 * 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        csum_err;
  logic        timeout_err;

  uart_cmd_parser #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .TIMEOUT_BYTES(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr),
    .cmd_data(cmd_data),
    .csum_err(csum_err),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_cerr   = 0;
  int n_tmo    = 0;

  // Frame-level reference model state
  logic [7:0]  mbuf[$];
  int          edge_n = 0;
  int          last_n = 0;
  logic        e_valid, e_cerr, e_tmo;
  logic [7:0]  e_addr;
  logic [15:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
  endtask

  task automatic model_reset();
    mbuf.delete();
    e_valid = 0; e_cerr = 0; e_tmo = 0; e_addr = '0; e_data = '0;
  endtask

  // Apply the frame rules to one sampled clock edge
  task automatic model_edge(input logic d, input logic [7:0] b);
    int s;
    e_valid = 0; e_cerr = 0; e_tmo = 0;
    edge_n++;
    if (d) begin
      last_n = edge_n;
      if (mbuf.size() == 0) begin
        if (b == 8'hAA) mbuf.push_back(b);
      end else if (mbuf.size() == 1) begin
        if (b == 8'h55) mbuf.push_back(b);
        else if (b != 8'hAA) mbuf.delete();
      end else begin
        mbuf.push_back(b);
        if (mbuf.size() == 6) begin
          s = (int'(mbuf[2]) + int'(mbuf[3]) + int'(mbuf[4])) % 256;
          if (s == int'(mbuf[5])) begin
            e_valid = 1;
            e_addr  = mbuf[2];
            e_data  = {mbuf[3], mbuf[4]};
          end else begin
            e_cerr = 1;
          end
          mbuf.delete();
        end
      end
    end else if (mbuf.size() != 0 && edge_n - last_n == T - 1) begin
      e_tmo = 1;
      mbuf.delete();
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge
  task automatic step(input logic d, input logic [7:0] b);
    rx_done = d;
    rx_data = b;
    @(posedge sys_clk);
    model_edge(d, b);
    #1;
    rx_done = 1'b0;
    if (cmd_valid)   n_valid++;
    if (csum_err)    n_cerr++;
    if (timeout_err) n_tmo++;
    chk("cycle {valid,cerr,tmo,addr,data}",
        32'({cmd_valid, csum_err, timeout_err, cmd_addr, cmd_data}),
        32'({e_valid, e_cerr, e_tmo, e_addr, e_data}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh,
                            input logic [7:0] dl, input logic corrupt);
    logic [7:0] cs;
    cs = 8'((int'(a) + int'(dh) + int'(dl)) % 256);
    if (corrupt) cs = cs ^ 8'(1 << $urandom_range(0, 7));
    step(1, 8'hAA); step(1, 8'h55); step(1, a); step(1, dh); step(1, dl); step(1, cs);
  endtask

  typedef struct {
    logic [7:0]  b [8];
    int          n;
    int          exp_valid;
    int          exp_cerr;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, c0, t0, first_tmo;
    logic [7:0] rb;

    vecs[0] = '{b: '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h9C, 8'h00, 8'h00}, n: 6,
                exp_valid: 1, exp_cerr: 0, exp_addr: 8'h12, exp_data: 16'h3456};
    vecs[1] = '{b: '{8'hAA, 8'h55, 8'h12, 8'h34, 8'h56, 8'h9D, 8'h00, 8'h00}, n: 6,
                exp_valid: 0, exp_cerr: 1, exp_addr: 8'h12, exp_data: 16'h3456};
    vecs[2] = '{b: '{8'h00, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'hFF, 8'hFF, 8'hFF}, n: 8,
                exp_valid: 1, exp_cerr: 0, exp_addr: 8'h01, exp_data: 16'hFFFF};
    vecs[3] = '{b: '{8'hAA, 8'h55, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00}, n: 6,
                exp_valid: 1, exp_cerr: 0, exp_addr: 8'h80, exp_data: 16'h8080};
    vecs[4] = '{b: '{8'hAA, 8'h00, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, n: 8,
                exp_valid: 1, exp_cerr: 0, exp_addr: 8'h00, exp_data: 16'h0000};
    vecs[5] = '{b: '{8'hAA, 8'h55, 8'hFE, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00}, n: 6,
                exp_valid: 0, exp_cerr: 1, exp_addr: 8'h00, exp_data: 16'h0000};

    sys_rst_n = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset outputs", 32'({cmd_valid, csum_err, timeout_err, cmd_addr, cmd_data}), 32'd0);
    sys_rst_n = 1'b1;
    idle(2);

    // Table of frames with fixed expectations
    for (int i = 0; i < 6; i++) begin
      v0 = n_valid; c0 = n_cerr; t0 = n_tmo;
      for (int j = 0; j < vecs[i].n; j++) step(1'b1, vecs[i].b[j]);
      idle(2);
      chk($sformatf("vec%0d valid count", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d csum_err count", i), 32'(n_cerr - c0), 32'(vecs[i].exp_cerr));
      chk($sformatf("vec%0d timeout count", i), 32'(n_tmo - t0), 32'd0);
      chk($sformatf("vec%0d cmd_addr", i), 32'(cmd_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d cmd_data", i), 32'(cmd_data), 32'(vecs[i].exp_data));
    end

    // Back-to-back frames with no gap
    v0 = n_valid;
    send_frame(8'h21, 8'h43, 8'h65, 1'b0);
    send_frame(8'hA5, 8'h5A, 8'hC3, 1'b0);
    idle(1);
    chk("b2b valid count", 32'(n_valid - v0), 32'd2);
    chk("b2b cmd_addr", 32'(cmd_addr), 32'h0000_00A5);
    chk("b2b cmd_data", 32'(cmd_data), 32'h0000_5AC3);

    // Timeout after AA 55 12, then a full frame is accepted
    step(1, 8'hAA); step(1, 8'h55); step(1, 8'h12);
    first_tmo = -1;
    t0 = n_tmo;
    for (int i = 1; i <= T + 5; i++) begin
      step(1'b0, 8'h00);
      if (timeout_err && first_tmo < 0) first_tmo = i;
    end
    chk("timeout cycle", 32'(first_tmo), 32'(T - 1));
    chk("timeout pulse count", 32'(n_tmo - t0), 32'd1);
    v0 = n_valid;
    send_frame(8'h33, 8'h44, 8'h55, 1'b0);
    idle(1);
    chk("post-timeout valid", 32'(n_valid - v0), 32'd1);
    chk("post-timeout cmd_addr", 32'(cmd_addr), 32'h33);

    // Race: byte in DATH lands on the terminal-count cycle
    v0 = n_valid; t0 = n_tmo;
    step(1, 8'hAA); step(1, 8'h55); step(1, 8'h12);
    idle(T - 2);
    step(1, 8'h34);
    step(1, 8'h56); step(1, 8'h9C);
    idle(2);
    chk("race timeout count", 32'(n_tmo - t0), 32'd0);
    chk("race valid count", 32'(n_valid - v0), 32'd1);
    chk("race cmd_data", 32'(cmd_data), 32'h3456);

    // Reset mid-frame
    step(1, 8'hAA); step(1, 8'h55); step(1, 8'h07);
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid-frame reset outputs",
        32'({cmd_valid, csum_err, timeout_err, cmd_addr, cmd_data}), 32'd0);
    repeat (2) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    v0 = n_valid; c0 = n_cerr; t0 = n_tmo;
    step(1, 8'hAA); step(1, 8'h55); step(1, 8'h07);
    step(1, 8'h00); step(1, 8'h01); step(1, 8'h08);
    idle(2);
    chk("after reset valid count", 32'(n_valid - v0), 32'd1);
    chk("after reset error count", 32'((n_cerr - c0) + (n_tmo - t0)), 32'd0);
    chk("after reset cmd_addr", 32'(cmd_addr), 32'h07);
    chk("after reset cmd_data", 32'(cmd_data), 32'h0001);

    // Random stream against the model
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        1: send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        2: begin
          for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
            case ($urandom_range(0, 3))
              0: rb = 8'hAA;
              1: rb = 8'h55;
              default: rb = 8'($urandom);
            endcase
            step(1'b1, rb);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
          end
        end
        default: begin
          step(1, 8'hAA); step(1, 8'h55);
          for (int j = 0; j < int'($urandom_range(0, 3)); j++) step(1'b1, 8'($urandom));
        end
      endcase
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(T - 3, T + 1)));
      else idle(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Byte-stream consumer placed directly downstream of uart_byte_rx. It takes each received byte (rx_data qualified by the rx_done pulse) and assembles fixed-format command frames. It validates the header and checksum, then emits a one-cycle command strobe carrying an 8-bit address and 16-bit data for the register/LED control logic further down. An inter-byte timeout discards partial frames.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
BAUD, 115200, UART bit rate; must match uart_byte_rx.
TIMEOUT_BYTES, 4, allowed idle gap mid-frame, in byte times.
TIMEOUT_CLKS, (CLK_FREQ/BAUD)*10*TIMEOUT_BYTES, derived idle limit in clocks (17360 at defaults); integer division.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst_n  input  1  asynchronous, active-low reset.
rx_data  input  8  received byte; valid only in the cycle rx_done=1.
rx_done  input  1  single-cycle strobe, one per received byte.
cmd_valid  output  1  one-cycle pulse: good frame decoded.
cmd_addr  output  8  address of last good frame.
cmd_data  output  16  data of last good frame, {DATA_H, DATA_L}.
csum_err  output  1  one-cycle pulse: checksum mismatch.
timeout_err  output  1  one-cycle pulse: partial frame abandoned.

Behaviour:
- Clock sys_clk; reset sys_rst_n, asynchronous, active-low.
- Frame format, 6 bytes: 0xAA, 0x55, ADDR, DATA_H, DATA_L, CSUM.
- CSUM = (ADDR + DATA_H + DATA_L) mod 256, using an 8-bit wrapping sum.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0, shadow regs 0.
- FSM states: IDLE, HDR2, ADDR, DATH, DATL, CSUM. Transitions occur only on cycles with rx_done=1, except on timeout.
  - IDLE: byte 0xAA goes to HDR2; any other byte stays in IDLE.
  - HDR2: byte 0x55 goes to ADDR; byte 0xAA stays in HDR2 (header resync); any other byte goes to IDLE. No error pulse in any of these cases.
  - ADDR: latch the byte into addr_sh, go to DATH.
  - DATH: latch into dh_sh, go to DATL.
  - DATL: latch into dl_sh, go to CSUM.
  - CSUM: compare the byte with the computed sum, then go to IDLE.
    - On match: cmd_addr<=addr_sh, cmd_data<={dh_sh,dl_sh}, cmd_valid=1 for exactly one cycle.
    - On mismatch: csum_err=1 for one cycle; cmd_addr/cmd_data are unchanged.
- Latency: cmd_valid and csum_err assert on the clock edge that registers the CSUM-byte rx_done, i.e. they are high the cycle after rx_done.
- cmd_addr/cmd_data hold their value until the next good frame. They update on the same edge that raises cmd_valid.
- Timeout counter:
  - Cleared on every rx_done and whenever the FSM is in IDLE.
  - Otherwise increments each clock.
  - When it reaches TIMEOUT_CLKS-1: FSM goes to IDLE, timeout_err pulses for one cycle, counter clears.
  - The counter saturates and never wraps.
- Simultaneous rx_done and timeout terminal count: rx_done wins. The byte is processed normally and the counter clears; no timeout_err.
- Back-to-back frames: a new 0xAA may arrive any time after the CSUM byte; no dead cycles are required.
- Reset mid-frame: FSM returns to IDLE immediately; outputs return to 0; the partial frame is discarded with no error pulse.
- cmd_valid, csum_err and timeout_err are mutually exclusive in any cycle.

Test Plan:
- Good frame: bytes AA 55 12 34 56 9C -> one cmd_valid pulse, cmd_addr=0x12, cmd_data=0x3456; no error pulses.
- Bad checksum: AA 55 12 34 56 9D -> csum_err for one cycle; cmd_valid stays 0; cmd_addr/cmd_data keep their prior values.
- Resync and junk: 00 AA AA 55 01 FF FF FF -> cmd_valid, addr=0x01, data=0xFFFF (csum 0xFF = 0x01+0xFF+0xFF mod 256).
- Timeout: AA 55 12, then silence for TIMEOUT_CLKS cycles -> timeout_err on cycle TIMEOUT_CLKS-1 after the last rx_done. A following full valid frame is then accepted.
- Race: rx_done coincides exactly with terminal count while in DATH -> byte latched, no timeout_err; the frame completes normally.
- Reset mid-frame: assert sys_rst_n=0 after AA 55 07, release, send AA 55 07 00 01 08 -> single cmd_valid, addr=0x07, data=0x0001.
